// File: rtl/cc_miss_req_ctrl.sv
// Cache miss request controller: captures a miss, issues one AXI WRAP burst read, tracks refills in flight.
// Optional CC_MISS_REQ_STATS_EN adds a saturating AR handshake counter on miss_cnt_o.
module cc_miss_req_ctrl #(
  parameter int unsigned MAX_OUTST = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        miss_req_i,
  input  logic [31:0] miss_addr_i,
  output logic        miss_ack_o,
  output logic        mem_arvalid_o,
  input  logic        mem_arready_i,
  output logic [31:0] mem_araddr_o,
  output logic [3:0]  mem_arlen_o,
  output logic [2:0]  mem_arsize_o,
  output logic [1:0]  mem_arburst_o,
  input  logic        miss_addr_fifo_full_i,
  output logic        miss_addr_fifo_wren_o,
  output logic [31:0] miss_addr_fifo_wdata_o,
  input  logic        fill_done_i,
  output logic [2:0]  outst_o,
  output logic        busy_o
`ifdef CC_MISS_REQ_STATS_EN
  ,
  output logic [15:0] miss_cnt_o
`endif
);

  typedef enum logic {IDLE, ISSUE} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q;
  logic [2:0]  outst_q, outst_nxt;
  logic        arvalid_q, busy_q;
  logic        capture, handshake, fill_ok;

  always_comb begin
    capture   = (state == IDLE) && miss_req_i && (outst_q < 3'(MAX_OUTST))
                && !miss_addr_fifo_full_i;
    handshake = (state == ISSUE) && mem_arready_i;
    fill_ok   = fill_done_i && (outst_q != '0);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (capture)   state_nxt = ISSUE;
      ISSUE:   if (handshake) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A handshake and a fill in the same cycle cancel out.
  always_comb begin
    outst_nxt = outst_q;
    if (handshake && !fill_ok)      outst_nxt = outst_q + 3'd1;
    else if (!handshake && fill_ok) outst_nxt = outst_q - 3'd1;
  end

  // arvalid and busy are registered from next-state values so they align with state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q    <= '0;
      outst_q   <= '0;
      arvalid_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      outst_q   <= outst_nxt;
      arvalid_q <= (state_nxt == ISSUE);
      busy_q    <= (outst_nxt != '0) || (state_nxt != IDLE);
      if (capture) addr_q <= {miss_addr_i[31:3], 3'b000};
    end
  end

`ifdef CC_MISS_REQ_STATS_EN
  logic [15:0] cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                            cnt_q <= '0;
    else if (handshake && cnt_q != '1)  cnt_q <= cnt_q + 16'd1;
  end

  assign miss_cnt_o = cnt_q;
`endif

  assign miss_ack_o             = handshake;
  assign miss_addr_fifo_wren_o  = handshake;
  assign miss_addr_fifo_wdata_o = addr_q;
  assign mem_arvalid_o          = arvalid_q;
  assign mem_araddr_o           = addr_q;
  assign mem_arlen_o            = 4'd7;
  assign mem_arsize_o           = 3'd3;
  assign mem_arburst_o          = 2'b10;
  assign outst_o                = outst_q;
  assign busy_o                 = busy_q;

endmodule

// File: tb/tb_cc_miss_req_ctrl.sv
// Self-checking bench for cc_miss_req_ctrl: directed table, corner sequences, random traffic vs a transaction model.
// Define CC_MISS_REQ_STATS_EN to also check miss_cnt_o.
module tb_cc_miss_req_ctrl;

  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        miss_req = 1'b0;
  logic [31:0] miss_addr = '0;
  logic        miss_ack;
  logic        arvalid;
  logic        arready = 1'b0;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        fifo_full = 1'b0;
  logic        fifo_wren;
  logic [31:0] fifo_wdata;
  logic        fill_done = 1'b0;
  logic [2:0]  outst;
  logic        busy;
`ifdef CC_MISS_REQ_STATS_EN
  logic [15:0] miss_cnt;
`endif

  cc_miss_req_ctrl #(.MAX_OUTST(MAX)) dut (
    .clk                    (clk),
    .rst                    (rst),
    .miss_req_i             (miss_req),
    .miss_addr_i            (miss_addr),
    .miss_ack_o             (miss_ack),
    .mem_arvalid_o          (arvalid),
    .mem_arready_i          (arready),
    .mem_araddr_o           (araddr),
    .mem_arlen_o            (arlen),
    .mem_arsize_o           (arsize),
    .mem_arburst_o          (arburst),
    .miss_addr_fifo_full_i  (fifo_full),
    .miss_addr_fifo_wren_o  (fifo_wren),
    .miss_addr_fifo_wdata_o (fifo_wdata),
    .fill_done_i            (fill_done),
    .outst_o                (outst),
    .busy_o                 (busy)
`ifdef CC_MISS_REQ_STATS_EN
    ,
    .miss_cnt_o             (miss_cnt)
`endif
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_total = 0;

  // Transaction-level model: one AR may be pending; refills in flight is a plain count.
  bit          m_pend;
  logic [31:0] m_addr;
  int          m_outst;
  int          m_cnt;

  logic        last_ack, last_wren;
  logic [31:0] last_wdata;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  task automatic model_reset();
    m_pend = 0; m_addr = '0; m_outst = 0; m_cnt = 0;
  endtask

  // Inputs are set by the caller just after a rising edge; outputs are checked mid-cycle.
  task automatic step();
    bit hs, cap;
    @(negedge clk);
    #1;
    hs = m_pend && arready;
    last_ack = miss_ack; last_wren = fifo_wren; last_wdata = fifo_wdata;
    chk("m_arvalid", {31'd0, arvalid}, {31'd0, m_pend});
    if (m_pend) chk("m_araddr", araddr, m_addr);
    chk("m_ack", {31'd0, miss_ack}, {31'd0, hs});
    chk("m_wren", {31'd0, fifo_wren}, {31'd0, hs});
    if (hs) chk("m_wdata", fifo_wdata, m_addr);
    chk("m_outst", {29'd0, outst}, 32'(m_outst));
    chk("m_busy", {31'd0, busy}, {31'd0, (m_outst != 0) || m_pend});
`ifdef CC_MISS_REQ_STATS_EN
    chk("m_cnt", {16'd0, miss_cnt}, 32'(m_cnt));
`endif
    cap = !m_pend && miss_req && (m_outst < MAX) && !fifo_full;
    m_outst = m_outst + (hs ? 1 : 0) - ((fill_done && m_outst > 0) ? 1 : 0);
    if (hs) begin
      m_pend = 0;
      if (m_cnt < 65535) m_cnt++;
    end
    if (cap) begin
      m_pend = 1;
      m_addr = miss_addr & 32'hFFFF_FFF8;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] addr;
    int          stall;
    logic [31:0] exp_araddr;
  } vec_t;

  vec_t vecs[4];

  task automatic run_miss(input vec_t v);
    int acks, pushes, waited;
    bit got;
    acks = 0; pushes = 0; waited = 0; got = 0;
    miss_req = 1; miss_addr = v.addr; arready = 0;
    step();
    acks += int'(last_ack); pushes += int'(last_wren);
    for (int s = 0; s < v.stall; s++) begin
      step();
      acks += int'(last_ack); pushes += int'(last_wren);
      chk("stall_arvalid", {31'd0, arvalid}, 32'd1);
      chk("stall_araddr", araddr, v.exp_araddr);
    end
    arready = 1;
    for (int k = 0; k < 3 && !got; k++) begin
      step();
      acks += int'(last_ack); pushes += int'(last_wren);
      if (last_ack) begin
        got = 1;
        waited = k;
        chk("hs_wdata", last_wdata, v.exp_araddr);
      end
    end
    chk("ack_seen", {31'd0, got}, 32'd1);
    chk("ack_latency", 32'(waited), 32'd0);
    miss_req = 0; arready = 0;
    chk("ack_count", 32'(acks), 32'd1);
    chk("push_count", 32'(pushes), 32'd1);
    chk("outst_after_ar", {29'd0, outst}, 32'd1);
    fill_done = 1;
    step();
    fill_done = 0;
    chk("outst_after_fill", {29'd0, outst}, 32'd0);
  endtask

  initial begin
    int acks;
    vecs[0] = '{addr: 32'h0001_2345, stall: 0, exp_araddr: 32'h0001_2340};
    vecs[1] = '{addr: 32'hFFFF_FFFF, stall: 5, exp_araddr: 32'hFFFF_FFF8};
    vecs[2] = '{addr: 32'h0000_0007, stall: 1, exp_araddr: 32'h0000_0000};
    vecs[3] = '{addr: 32'h8000_000C, stall: 3, exp_araddr: 32'h8000_0008};

    model_reset();
    #3;
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_ack", {31'd0, miss_ack}, 32'd0);
    chk("rst_wren", {31'd0, fifo_wren}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_outst", {29'd0, outst}, 32'd0);
    chk("arlen", {28'd0, arlen}, 32'd7);
    chk("arsize", {29'd0, arsize}, 32'd3);
    chk("arburst", {30'd0, arburst}, 32'd2);
    @(posedge clk); @(posedge clk); #1;
    rst = 0;

    foreach (vecs[i]) run_miss(vecs[i]);

    // Outstanding limit: five back-to-back misses, no fills.
    miss_req = 1; miss_addr = 32'h0000_1000; arready = 1; acks = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (last_ack) begin acks++; miss_addr = miss_addr + 32'h40; end
    end
    chk("limit_acks", 32'(acks), 32'd4);
    chk("limit_outst", {29'd0, outst}, 32'd4);
    chk("limit_arvalid", {31'd0, arvalid}, 32'd0);
    fill_done = 1;
    step();
    fill_done = 0; acks = 0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (last_ack) begin acks++; miss_req = 0; end
    end
    miss_req = 0;
    chk("limit_fifth_ack", 32'(acks), 32'd1);
    chk("limit_outst_back", {29'd0, outst}, 32'd4);

    // Handshake and fill in the same cycle at outst=2.
    fill_done = 1; step(); step(); fill_done = 0;
    chk("sim_outst_pre", {29'd0, outst}, 32'd2);
    miss_req = 1; miss_addr = 32'h0000_2008; arready = 1;
    step();
    fill_done = 1;
    step();
    chk("sim_ack", {31'd0, last_ack}, 32'd1);
    miss_req = 0; fill_done = 0;
    chk("sim_outst", {29'd0, outst}, 32'd2);
    fill_done = 1; step(); step(); step(); fill_done = 0;
    chk("underflow_outst", {29'd0, outst}, 32'd0);

    // FIFO full blocks capture.
    fifo_full = 1; miss_req = 1; miss_addr = 32'h0000_3010; arready = 1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("full_no_arvalid", {31'd0, arvalid}, 32'd0);
    end
    fifo_full = 0;
    step();
    chk("full_release_arvalid", {31'd0, arvalid}, 32'd1);
    step();
    chk("full_release_ack", {31'd0, last_ack}, 32'd1);
    miss_req = 0; arready = 0;
    fill_done = 1; step(); fill_done = 0;

    // Asynchronous reset while an AR is pending.
    miss_req = 1; miss_addr = 32'h0000_4020; arready = 0;
    step();
    chk("pre_rst_arvalid", {31'd0, arvalid}, 32'd1);
    #2 rst = 1;
    #1;
    chk("async_rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("async_rst_wren", {31'd0, fifo_wren}, 32'd0);
    chk("async_rst_ack", {31'd0, miss_ack}, 32'd0);
    chk("async_rst_outst", {29'd0, outst}, 32'd0);
    chk("async_rst_busy", {31'd0, busy}, 32'd0);
`ifdef CC_MISS_REQ_STATS_EN
    chk("async_rst_cnt", {16'd0, miss_cnt}, 32'd0);
`endif
    @(posedge clk); #1;
    rst = 0;
    model_reset();
    miss_addr = 32'h0000_5030;
    step();
    chk("first_capture_after_rst", {31'd0, arvalid}, 32'd1);
    chk("first_capture_addr", araddr, 32'h0000_5030);
    arready = 1;
    step();
    chk("post_rst_ack", {31'd0, last_ack}, 32'd1);
    miss_req = 0; arready = 0;

    // Random traffic against the model.
    for (int i = 0; i < 600; i++) begin
      if (!miss_req && $urandom_range(0, 2) == 0) begin
        miss_req = 1;
        miss_addr = $urandom;
      end
      arready   = 1'($urandom_range(0, 1));
      fifo_full = ($urandom_range(0, 5) == 0);
      fill_done = ($urandom_range(0, 3) == 0);
      step();
      if (last_ack) miss_req = 0;
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
